// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave register bank: C_NUM_CH user channels captured on per-channel
// strobes (plain capture or sticky-OR), exposed read-only to the PPC, plus
// freeze control, fresh flags and a saturating dropped-update counter.
// Bus vectors are declared descending: pin bit [31] is the OPB's big-endian
// bit 0 (MSB), and OPB_BE[0] here is the OPB's BE[3] (least significant lane).

// One channel: data register and its fresh flag.
module opb_rb_chan #(
  parameter bit STICKY = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        upd_i,
  input  logic        clr_i,
  input  logic        rd_clr_i,
  input  logic [31:0] data_i,
  output logic [31:0] ch_o,
  output logic        fresh_o
);
  logic [31:0] ch_q, ch_d;
  logic        fresh_q, fresh_d;

  // Next state: clear and OR combine as 0|data; update beats read-clear of fresh.
  always_comb begin
    ch_d    = ch_q;
    fresh_d = fresh_q;
    if (upd_i) begin
      ch_d    = STICKY ? (((STICKY && clr_i) ? 32'h0 : ch_q) | data_i) : data_i;
      fresh_d = 1'b1;
    end else begin
      if (STICKY && clr_i) ch_d = 32'h0;
      if (rd_clr_i)        fresh_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q    <= 32'h0;
      fresh_q <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      fresh_q <= fresh_d;
    end
  end

  assign ch_o    = ch_q;
  assign fresh_o = fresh_q;
endmodule

module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR    = 32'h01080800,
  parameter logic [31:0] C_HIGHADDR    = 32'h010808FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_CH      = 4,
  parameter logic [15:0] C_STICKY_MASK = 16'h0000,
  parameter string       C_FAMILY      = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  output logic [C_OPB_DWIDTH-1:0]     Sl_DBus,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic                        Sl_xferAck,
  input  logic [C_OPB_AWIDTH-1:0]     OPB_ABus,
  input  logic [3:0]                  OPB_BE,
  input  logic [C_OPB_DWIDTH-1:0]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  input  logic [C_NUM_CH*32-1:0]      user_data_in,
  input  logic [C_NUM_CH-1:0]         user_valid
);
  localparam bit FAMILY_V5 = (C_FAMILY == "virtex5");

  logic                       ack_q, ack_d;
  logic [C_OPB_DWIDTH-1:0]    dbus_q, dbus_d, rd_data;
  logic                       freeze_q, freeze_d;
  logic [15:0]                drops_q, drops_d;
  logic [C_OPB_AWIDTH-1:0]    off_full;
  logic [7:0]                 off;
  logic [3:0]                 idx;
  logic                       in_win, hit, rd_hit, wr_hit, ch_sel;
  logic                       ctrl_wr, clr_sticky, drops_clr, drops_inc;
  logic [C_NUM_CH-1:0]        upd, rd_clr, fresh_w;
  logic [C_NUM_CH-1:0][31:0]  ch_w;
  logic                       unused_ok;

  assign in_win   = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  // Ack suppresses the next hit so a held select acks every other cycle.
  assign hit      = OPB_select & in_win & ~ack_q;
  assign rd_hit   = hit & OPB_RNW;
  assign wr_hit   = hit & ~OPB_RNW;
  assign off_full = OPB_ABus - C_BASEADDR;
  assign off      = off_full[7:0];
  assign idx      = off[5:2];
  assign ch_sel   = (off[7:6] == 2'b00) && (off[1:0] == 2'b00);

  assign ctrl_wr    = wr_hit & (off == 8'h80) & OPB_BE[0];
  assign clr_sticky = ctrl_wr & OPB_DBus[1];
  assign freeze_d   = ctrl_wr ? OPB_DBus[0] : freeze_q;
  assign drops_clr  = wr_hit & (off == 8'h8C);
  // One count per edge with any strobe, not per strobe bit.
  assign drops_inc  = freeze_q & (|user_valid) & (drops_q != 16'hFFFF);
  assign upd        = freeze_q ? '0 : user_valid;

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    opb_rb_chan #(.STICKY(C_STICKY_MASK[i])) u_ch (
      .clk_i    (OPB_Clk),
      .rst_i    (OPB_Rst),
      .upd_i    (upd[i]),
      .clr_i    (clr_sticky),
      .rd_clr_i (rd_clr[i]),
      .data_i   (user_data_in[32*i +: 32]),
      .ch_o     (ch_w[i]),
      .fresh_o  (fresh_w[i])
    );
  end

  // Read mux over pre-update state; also flags which channel's fresh to clear.
  always_comb begin
    rd_data = '0;
    rd_clr  = '0;
    if (ch_sel) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (idx == 4'(i)) begin
          rd_data   = C_OPB_DWIDTH'(ch_w[i]);
          rd_clr[i] = rd_hit;
        end
      end
    end else begin
      case (off)
        8'h80:   rd_data = C_OPB_DWIDTH'(freeze_q);
        8'h84:   rd_data = C_OPB_DWIDTH'(fresh_w);
        8'h88:   rd_data = C_OPB_DWIDTH'(C_NUM_CH);
        8'h8C:   rd_data = C_OPB_DWIDTH'(drops_q);
        default: rd_data = '0;
      endcase
    end
  end

  // Bus response and drop counter next state; DROPS write beats increment.
  always_comb begin
    ack_d   = hit;
    dbus_d  = rd_hit ? rd_data : '0;
    drops_d = drops_q;
    if (drops_clr)      drops_d = 16'h0;
    else if (drops_inc) drops_d = drops_q + 16'h1;
  end

  // Control and bus response registers.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ack_q    <= 1'b0;
      dbus_q   <= '0;
      freeze_q <= 1'b0;
      drops_q  <= 16'h0;
    end else begin
      ack_q    <= ack_d;
      dbus_q   <= dbus_d;
      freeze_q <= freeze_d;
      drops_q  <= drops_d;
    end
  end

  assign Sl_xferAck = ack_q;
  assign Sl_DBus    = dbus_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[3:1], off_full[C_OPB_AWIDTH-1:8],
                       OPB_DBus[C_OPB_DWIDTH-1:2], FAMILY_V5};
endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Bench for opb_register_bank_simulink2ppc: directed scenarios plus random
// traffic, every cycle compared against a behavioural model of the bank.
module tb_opb_register_bank_simulink2ppc;
  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h01080800;
  localparam logic [31:0] HIGH   = 32'h010808FF;
  localparam logic [15:0] STICKY = 16'h0001;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]    dbus_o;
  logic           err, retry, tout, ack;
  logic [31:0]    addr = '0, wd = '0;
  logic [3:0]     be = 4'hF;
  logic           rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic [N*32-1:0] ud = '0;
  logic [N-1:0]   uv = '0;

  opb_register_bank_simulink2ppc #(
    .C_NUM_CH(N), .C_STICKY_MASK(STICKY)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .Sl_DBus(dbus_o), .Sl_errAck(err),
    .Sl_retry(retry), .Sl_toutSup(tout), .Sl_xferAck(ack), .OPB_ABus(addr),
    .OPB_BE(be), .OPB_DBus(wd), .OPB_RNW(rnw), .OPB_select(sel),
    .OPB_seqAddr(seq), .user_data_in(ud), .user_valid(uv)
  );

  // Reference model state
  logic [31:0]  m_ch [N];
  logic [N-1:0] m_fresh;
  bit           m_freeze, m_ack;
  int           m_drops;
  logic [31:0]  m_dbus;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_ch[i] = '0;
    m_fresh = '0; m_freeze = 0; m_ack = 0; m_drops = 0; m_dbus = '0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] off);
    if (off < 32'(4*N) && off % 4 == 0) return m_ch[off/4];
    case (off)
      32'h80:  return {31'b0, m_freeze};
      32'h84:  return 32'(m_fresh);
      32'h88:  return 32'(N);
      32'h8C:  return 32'(m_drops);
      default: return 32'h0;
    endcase
  endfunction

  // Apply one clock edge of the bank's rules to the model.
  function automatic void model_step();
    bit          inwin = (addr >= BASE) && (addr <= HIGH);
    bit          hit   = sel && inwin && !m_ack;
    logic [31:0] off   = addr - BASE;
    logic [31:0] rdv   = (hit && rnw) ? m_read(off) : 32'h0;
    bit          clr   = 0;
    bit          nfrz  = m_freeze;
    if (hit && !rnw && off == 32'h80 && be[0]) begin nfrz = wd[0]; clr = wd[1]; end
    if (hit && !rnw && off == 32'h8C) m_drops = 0;
    else if (m_freeze && uv != 0 && m_drops < 65535) m_drops++;
    for (int i = 0; i < N; i++) begin
      logic [31:0] d = ud[32*i +: 32];
      bit st = STICKY[i];
      if (!m_freeze && uv[i]) begin
        m_fresh[i] = 1'b1;
        m_ch[i] = st ? ((clr ? 32'h0 : m_ch[i]) | d) : d;
      end else begin
        if (clr && st) m_ch[i] = 32'h0;
        if (hit && rnw && off == 32'(4*i)) m_fresh[i] = 1'b0;
      end
    end
    m_freeze = nfrz; m_ack = hit; m_dbus = rdv;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("ack", {31'b0, ack}, {31'b0, m_ack});
    chk("dbus", dbus_o, m_dbus);
    chk("tied0", {29'b0, err, retry, tout}, 32'h0);
  endtask

  // Strobes set by the caller apply in the hit cycle and are then dropped.
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    sel = 1; rnw = 1; addr = BASE + a;
    tick();
    d = dbus_o;
    chk("rd_ack", {31'b0, ack}, 32'h1);
    sel = 0; uv = '0;
    tick();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] b);
    sel = 1; rnw = 0; addr = BASE + a; wd = v; be = b;
    tick();
    chk("wr_ack", {31'b0, ack}, 32'h1);
    sel = 0; uv = '0; be = 4'hF;
    tick();
  endtask

  logic [31:0] d;
  logic [31:0] offs [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h02,
                             32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'hFC};

  initial begin
    m_reset();
    #12;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dbus", dbus_o, 32'h0);
    @(negedge clk); rst = 0;

    // INFO after reset
    bus_rd(32'h88, d); chk("info", d, 32'h4);

    // Capture channel 1 and fresh handling
    uv = 4'b0010; ud[63:32] = 32'hDEADBEEF; tick(); uv = '0;
    bus_rd(32'h84, d); chk("fresh1", d, 32'h2);
    bus_rd(32'h04, d); chk("ch1", d, 32'hDEADBEEF);
    bus_rd(32'h84, d); chk("fresh1_clr", d, 32'h0);

    // Sticky channel 0, then clear_sticky with simultaneous strobe
    uv = 4'b0001; ud[31:0] = 32'h00F0; tick();
    ud[31:0] = 32'h0F00; tick(); uv = '0;
    bus_rd(32'h00, d); chk("sticky_or", d, 32'h00000FF0);
    uv = 4'b0001; ud[31:0] = 32'h1;
    bus_wr(32'h80, 32'h2, 4'hF);
    bus_rd(32'h00, d); chk("sticky_clr", d, 32'h1);
    bus_rd(32'h80, d); chk("ctrl_pulse", d, 32'h0);

    // Freeze and drop counting
    bus_wr(32'h80, 32'h1, 4'hF);
    for (int k = 0; k < 5; k++) begin
      uv = (k == 2) ? 4'b0111 : 4'b0010; ud[63:32] = $urandom; tick();
    end
    uv = '0;
    bus_rd(32'h04, d); chk("frozen_ch1", d, 32'hDEADBEEF);
    bus_rd(32'h8C, d); chk("drops5", d, 32'h5);
    bus_wr(32'h8C, 32'h0, 4'h0);
    bus_rd(32'h8C, d); chk("drops_clr", d, 32'h0);
    bus_wr(32'h80, 32'h0, 4'b1110);
    bus_rd(32'h80, d); chk("ctrl_be_off", d, 32'h1);
    bus_wr(32'h80, 32'h0, 4'hF);
    uv = 4'b1000; ud[127:96] = 32'hA5A5A5A5; tick(); uv = '0;
    bus_rd(32'h0C, d); chk("unfrozen_ch3", d, 32'hA5A5A5A5);

    // Read racing an update returns the old value, fresh stays set
    uv = 4'b0100; ud[95:64] = 32'h11112222; tick(); uv = '0;
    bus_rd(32'h08, d); chk("ch2_old_setup", d, 32'h11112222);
    uv = 4'b0100; ud[95:64] = 32'h12345678;
    bus_rd(32'h08, d); chk("ch2_race", d, 32'h11112222);
    bus_rd(32'h84, d); chk("fresh2_kept", d & 32'h4, 32'h4);
    bus_rd(32'h08, d); chk("ch2_new", d, 32'h12345678);

    // Held select: ack every other cycle; out-of-window never acked
    sel = 1; rnw = 1; addr = BASE + 32'h40;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("hold_ack", {31'b0, ack}, 32'((k % 2) == 0));
      chk("hold_dbus", dbus_o, 32'h0);
    end
    addr = 32'h01080900;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("oow_ack", {31'b0, ack}, 32'h0);
    end
    sel = 0; tick();

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      sel  = ($urandom_range(0, 9) < 5);
      case ($urandom_range(0, 7))
        0:       addr = BASE - 32'h4;
        1:       addr = HIGH + 32'h1;
        default: addr = BASE + offs[$urandom_range(0, 11)];
      endcase
      rnw  = ($urandom_range(0, 3) != 0);
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      uv   = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < N; i++) ud[32*i +: 32] = $urandom;
      tick();
    end
    sel = 0; uv = '0; be = 4'hF; tick(); tick();

    // Reset in the middle of an ack drops it at once
    sel = 1; rnw = 1; addr = BASE + 32'h88;
    tick();
    #2 rst = 1;
    #1;
    chk("rst_mid_ack", {31'b0, ack}, 32'h0);
    chk("rst_mid_dbus", dbus_o, 32'h0);
    sel = 0; m_reset();
    @(negedge clk); rst = 0;
    bus_rd(32'h04, d); chk("post_rst_ch1", d, 32'h0);
    bus_rd(32'h8C, d); chk("post_rst_drops", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
